// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial ripple adder. Adds two WIDTH-bit unsigned operands plus a
//   carry-in, LSB first, one bit per clock, using one full-adder cell and a
//   carry flip-flop. A start/busy/done handshake connects it to a controlling
//   FSM. The latency is WIDTH cycles from the accepted start edge to done.
//   Back-to-back operation gives one result every WIDTH+2 cycles.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (aborts any addition in flight)
//   start  in   request, sampled only while idle
//   a, b   in   operands, captured on the accepted start edge
//   cin    in   carry-in, captured on the accepted start edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse; sum/cout are valid from here on
//   sum    out  (a+b+cin) mod 2^WIDTH, held until the next accepted start
//   cout   out  carry out of bit WIDTH-1, held with sum
//   ovf    out  signed two's-complement overflow (only when the
//               SERIAL_ADDER_OVF_EN macro is defined)
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_nxt;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  // The single full-adder cell works on the current LSBs of the shift registers.
  always_comb begin
    s_bit = fa_sum(a_sr[0], b_sr[0], c);
    c_nxt = fa_carry(a_sr[0], b_sr[0], c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            c     <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          // Result bits enter at the MSB so that after WIDTH shifts the
          // first (LSB) result bit has reached position 0.
          sum  <= {s_bit, sum[WIDTH-1:1]};
          c    <= c_nxt;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          if (cnt == LAST_BIT) begin
            cout  <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
            // c is the carry into the MSB, c_nxt the carry out of it.
            ovf   <= c ^ c_nxt;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Scoreboard bench for serial_adder. Drivers push the expected
//   {ovf, cout, sum} of every accepted operation into a queue. A monitor
//   running on the falling edge pops one entry whenever done is high and
//   compares it with the DUT outputs. It also checks that sum/cout stay
//   stable between done and the next start, and that busy and done are
//   never high together.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH+1:0] exp_q[$];

  logic             hold_valid = 1'b0;
  logic [WIDTH-1:0] hold_sum   = '0;
  logic             hold_cout  = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic. ovf is true when the signed sum
  // falls outside the signed WIDTH-bit range.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic ci);
    int unsigned u;
    int          sx;
    int          sy;
    int          s;
    logic        ov;
    u  = 32'(x) + 32'(y) + 32'(ci);
    sx = $signed(x);
    sy = $signed(y);
    s  = sx + sy + int'(ci);
    ov = (s > (2 ** (WIDTH - 1)) - 1) || (s < -(2 ** (WIDTH - 1)));
    return {ov, u[WIDTH], u[WIDTH-1:0]};
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [WIDTH+1:0] e;
    check("busy_done_exclusive", 64'(busy & done), 64'(0));
    if (rst) begin
      hold_valid <= 1'b0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("sum", 64'(sum), 64'(e[WIDTH-1:0]));
        check("cout", 64'(cout), 64'(e[WIDTH]));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 64'(ovf), 64'(e[WIDTH+1]));
`endif
      end
      hold_valid <= 1'b1;
      hold_sum   <= sum;
      hold_cout  <= cout;
    end else if (busy) begin
      hold_valid <= 1'b0;
    end else if (hold_valid) begin
      check("result_hold", 64'({cout, sum}), 64'({hold_cout, hold_sum}));
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 4 * WIDTH + 10; k++) begin
      if (!busy && !done) return;
      @(posedge clk);
      #1;
    end
    check("wait_idle_timeout", 64'(1), 64'(0));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    int   lat;
    logic busy_ok;
    wait_idle();
    start = 1'b1;
    a     = x;
    b     = y;
    cin   = ci;
    exp_q.push_back(model(x, y, ci));
    @(posedge clk);
    #1;
    start   = 1'b0;
    // Operands are don't-care once captured.
    a       = WIDTH'($urandom);
    b       = WIDTH'($urandom);
    cin     = 1'($urandom);
    lat     = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
    end
    check("latency", 64'(lat), 64'(WIDTH));
    check("busy_during_shift", 64'(busy_ok), 64'(1));
  endtask

  initial begin
    int done_cnt;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("reset_ovf", 64'(ovf), 64'(0));
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, including carry-out and signed-overflow corners.
    run_op(8'h3C, 8'h05, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h7F, 8'h00, 1'b1);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h00, 8'h00, 1'b0);

    // start held high: one acceptance every WIDTH+2 cycles.
    wait_idle();
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h20;
    cin   = 1'b0;
    repeat (3) exp_q.push_back(model(8'h10, 8'h20, 1'b0));
    for (int cyc = 0; cyc < 3 * (WIDTH + 2); cyc++) begin
      @(posedge clk);
      #1;
      check("held_start_done", 64'(done), 64'((cyc % (WIDTH + 2)) == WIDTH));
      if (((cyc + 1) % (WIDTH + 2)) == 0) begin
        a   = 8'h10;
        b   = 8'h20;
        cin = 1'b0;
      end else begin
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        cin = 1'($urandom);
      end
    end
    start = 1'b0;

    // Reset three cycles into an addition aborts it without a done pulse.
    wait_idle();
    start = 1'b1;
    a     = 8'h55;
    b     = 8'h66;
    cin   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_sum", 64'(sum), 64'(0));
    check("abort_cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("abort_ovf", 64'(ovf), 64'(0));
`endif
    rst      = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'(0));
    run_op(8'h55, 8'h66, 1'b1);

    // Randomized sweep.
    for (int n = 0; n < 1000; n++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
